// File: rtl/pin_lock_ctrl_if.sv
// Keypad-side bundle between the debounced front end and the PIN lock controller.
interface pin_lock_ctrl_if #(
  parameter int unsigned MAX_FAIL = 3
);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);

  logic          enter;
  logic [1:0]    digit;
  logic          clear;
  logic          open;
  logic          locked_out;
  logic          fail_pulse;
  logic [FW-1:0] fail_cnt;
  logic [2:0]    state_dbg;

  modport master (
    output enter, digit, clear,
    input  open, locked_out, fail_pulse, fail_cnt, state_dbg
  );

  modport slave (
    input  enter, digit, clear,
    output open, locked_out, fail_pulse, fail_cnt, state_dbg
  );
endinterface

// File: rtl/pin_lock_ctrl.sv
// 3-digit PIN entry sequencer with timed unlock, entry timeout and failure lockout.
module pin_lock_ctrl #(
  parameter logic [1:0]  CODE0          = 2'b00,
  parameter logic [1:0]  CODE1          = 2'b01,
  parameter logic [1:0]  CODE2          = 2'b10,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned OPEN_CYCLES    = 500,
  parameter int unsigned LOCK_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic           clk,
  input  logic           rst,
  pin_lock_ctrl_if.slave bus
);

  localparam int unsigned MAX_OL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned MAX_T  = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
  localparam int unsigned TW     = $clog2(MAX_T + 1);
  localparam int unsigned FW     = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_GOT1    = 3'b001,
    S_GOT2    = 3'b010,
    S_EVAL    = 3'b011,
    S_OPEN    = 3'b100,
    S_FAIL    = 3'b101,
    S_LOCKOUT = 3'b110
  } state_t;

  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic          open_q, locked_q, fail_pulse_q;
  logic          timeout;

  // Digit-wait expiry shared by GOT1 and GOT2.
  assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // State, error flag, timer, failure count and decoded outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      err_q        <= 1'b0;
      timer_q      <= '0;
      fail_cnt_q   <= '0;
      open_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
      fail_cnt_q   <= fail_cnt_d;
      open_q       <= (state_d == S_OPEN);
      locked_q     <= (state_d == S_LOCKOUT);
      fail_pulse_q <= (state_d == S_FAIL);
    end
  end

  // Next-state, error accumulation and failure bookkeeping.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enter) begin
          state_d = S_GOT1;
          err_d   = (bus.digit != CODE0);
        end
      end
      S_GOT1: begin
        if (bus.clear) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else if (bus.enter) begin
          state_d = S_GOT2;
          err_d   = err_q | (bus.digit != CODE1);
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      S_GOT2: begin
        if (bus.clear) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else if (bus.enter) begin
          state_d = S_EVAL;
          err_d   = err_q | (bus.digit != CODE2);
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      S_EVAL: begin
        err_d = 1'b0;
        if (!err_q) begin
          state_d    = S_OPEN;
          fail_cnt_d = '0;
        end else if ((32'(fail_cnt_q) + 32'd1) == MAX_FAIL) begin
          state_d    = S_LOCKOUT;
          fail_cnt_d = FW'(MAX_FAIL);
        end else begin
          state_d    = S_FAIL;
          fail_cnt_d = fail_cnt_q + FW'(1);
        end
      end
      S_FAIL: state_d = S_IDLE;
      S_OPEN: begin
        if (timer_q == TW'(OPEN_CYCLES - 1)) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Single timer restarts on every state change.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (state_d != state_q) timer_d = '0;
  end

  assign bus.open       = open_q;
  assign bus.locked_out = locked_q;
  assign bus.fail_pulse = fail_pulse_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Vector/scoreboard bench for pin_lock_ctrl with short timing parameters.
module tb_pin_lock_ctrl;

  localparam int unsigned MAX_FAIL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pin_lock_ctrl_if #(.MAX_FAIL(MAX_FAIL)) bus ();

  pin_lock_ctrl #(
    .CODE0(2'b00), .CODE1(2'b01), .CODE2(2'b10),
    .MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(4), .LOCK_CYCLES(8), .TIMEOUT_CYCLES(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] dg;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         vec_idx  = 0;

  // {state_dbg, open, locked_out, fail_pulse, fail_cnt}
  function automatic logic [7:0] observed();
    return {bus.state_dbg, bus.open, bus.locked_out, bus.fail_pulse, bus.fail_cnt};
  endfunction

  function automatic logic [7:0] pack_exp(logic [2:0] st, logic [1:0] fc);
    return {st, st == 3'd4, st == 3'd6, st == 3'd5, fc};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got st=%b open=%b lock=%b fp=%b cnt=%0d, expected st=%b open=%b lock=%b fp=%b cnt=%0d",
               name, act[7:5], act[4], act[3], act[2], act[1:0],
               exp[7:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic add(logic en, logic [1:0] dg, logic clr, logic [2:0] st, logic [1:0] fc);
    vec_t v;
    v.en = en; v.dg = dg; v.clr = clr; v.exp = pack_exp(st, fc);
    vecs.push_back(v);
  endtask

  // Quiet cycles; digit toggles randomly since it must be ignored without enter.
  task automatic idle(int n, logic [2:0] st, logic [1:0] fc);
    for (int i = 0; i < n; i++) add(1'b0, 2'($urandom_range(0, 3)), 1'b0, st, fc);
  endtask

  // One wrong attempt starting from IDLE with count c; ends back in IDLE.
  task automatic wrong_attempt(logic [1:0] c);
    add(1'b1, 2'b11, 1'b0, 3'd1, c);
    add(1'b1, 2'b01, 1'b0, 3'd2, c);
    add(1'b1, 2'b10, 1'b0, 3'd3, c);
    idle(1, 3'd5, c + 2'd1);
    idle(1, 3'd0, c + 2'd1);
  endtask

  // Apply queued vectors from a falling edge; each result is checked one cycle later.
  task automatic run_vecs();
    logic [7:0] e;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.enter = vecs[i].en;
      bus.digit = vecs[i].dg;
      bus.clear = vecs[i].clr;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d", vec_idx), observed(), e);
      vec_idx++;
    end
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    vecs.delete();
  endtask

  initial begin
    bus.enter = 1'b0;
    bus.digit = 2'b00;
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", observed(), 8'h00);
    rst = 1'b0;

    // Correct code, non-adjacent enters.
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd0);
    idle(1, 3'd1, 2'd0);
    add(1'b1, 2'b01, 1'b0, 3'd2, 2'd0);
    idle(1, 3'd2, 2'd0);
    add(1'b1, 2'b10, 1'b0, 3'd3, 2'd0);
    idle(4, 3'd4, 2'd0);
    idle(1, 3'd0, 2'd0);
    // Wrong first digit still walks through all states.
    add(1'b1, 2'b11, 1'b0, 3'd1, 2'd0);
    idle(1, 3'd1, 2'd0);
    add(1'b1, 2'b01, 1'b0, 3'd2, 2'd0);
    add(1'b1, 2'b10, 1'b0, 3'd3, 2'd0);
    idle(1, 3'd5, 2'd1);
    idle(2, 3'd0, 2'd1);
    // Second failure, then third (wrong last digit) goes to lockout.
    wrong_attempt(2'd1);
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd2);
    add(1'b1, 2'b01, 1'b0, 3'd2, 2'd2);
    add(1'b1, 2'b11, 1'b0, 3'd3, 2'd2);
    idle(1, 3'd6, 2'd3);
    for (int k = 0; k < 7; k++) add(1'b1, 2'(k), 1'(k), 3'd6, 2'd3);
    add(1'b1, 2'b00, 1'b0, 3'd0, 2'd0);
    idle(1, 3'd0, 2'd0);
    // Recovery after two failures.
    wrong_attempt(2'd0);
    wrong_attempt(2'd1);
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd2);
    add(1'b1, 2'b01, 1'b0, 3'd2, 2'd2);
    add(1'b1, 2'b10, 1'b0, 3'd3, 2'd2);
    idle(4, 3'd4, 2'd0);
    idle(1, 3'd0, 2'd0);
    // Timeouts and clear with a nonzero failure count.
    wrong_attempt(2'd0);
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd1);
    idle(5, 3'd1, 2'd1);
    idle(2, 3'd0, 2'd1);
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd1);
    idle(4, 3'd1, 2'd1);
    add(1'b1, 2'b01, 1'b0, 3'd2, 2'd1);
    add(1'b1, 2'b10, 1'b1, 3'd0, 2'd1);
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd1);
    add(1'b0, 2'b00, 1'b1, 3'd0, 2'd1);
    add(1'b0, 2'b00, 1'b1, 3'd0, 2'd1);
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd1);
    add(1'b1, 2'b01, 1'b0, 3'd2, 2'd1);
    idle(5, 3'd2, 2'd1);
    idle(1, 3'd0, 2'd1);
    run_vecs();

    // Async reset in the middle of OPEN.
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd1);
    add(1'b1, 2'b01, 1'b0, 3'd2, 2'd1);
    add(1'b1, 2'b10, 1'b0, 3'd3, 2'd1);
    idle(2, 3'd4, 2'd0);
    run_vecs();
    #2 rst = 1'b1;
    #1 check("async_rst_open", observed(), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of LOCKOUT with the count saturated.
    wrong_attempt(2'd0);
    wrong_attempt(2'd1);
    add(1'b1, 2'b11, 1'b0, 3'd1, 2'd2);
    add(1'b1, 2'b11, 1'b0, 3'd2, 2'd2);
    add(1'b1, 2'b11, 1'b0, 3'd3, 2'd2);
    idle(3, 3'd6, 2'd3);
    run_vecs();
    #2 rst = 1'b1;
    #1 check("async_rst_lockout", observed(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    idle(1, 3'd0, 2'd0);
    add(1'b1, 2'b00, 1'b0, 3'd1, 2'd0);
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
